// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock supervisor: reset pulse, lock qualification, retry and fail
module pll_lock_supervisor #(
   parameter int RST_CYCLES   = 50,
   parameter int LOCK_TIMEOUT = 50000,
   parameter int LOCK_STABLE  = 1024,
   parameter int MAX_RETRY    = 3,
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
   input  logic          clkin,
   input  logic          reset,
   input  logic          pll_lock,
   input  logic          relock_req,
   output logic          pll_rst,
   output logic          locked,
   output logic          sys_rst,
   output logic          fail,
   output logic [RW-1:0] retry_cnt
);

   localparam int CMAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
   localparam int CMAX   = (CMAX_A > LOCK_STABLE) ? CMAX_A : LOCK_STABLE;
   localparam int CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

   typedef enum logic [2:0] {
      PRST      = 3'd0,
      WAIT_LOCK = 3'd1,
      QUAL      = 3'd2,
      LOCKED    = 3'd3,
      FAIL      = 3'd4
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt;
   logic [1:0]      sync_q;
   logic            lock_s;
   logic [RW-1:0]   retry_nxt;

   assign lock_s = sync_q[1];

   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], pll_lock};
      end
   end

   // relock_req overrides any same-cycle lock/timeout event, except in PRST where it is ignored
   always_comb begin
      state_nxt = state;
      retry_nxt = retry_cnt;
      if (relock_req && (state != PRST)) begin
         state_nxt = PRST;
         retry_nxt = '0;
      end else begin
         case (state)
            PRST: begin
               if (cnt == CW'(RST_CYCLES - 1)) state_nxt = WAIT_LOCK;
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state_nxt = QUAL;
               end else if (cnt == CW'(LOCK_TIMEOUT - 1)) begin
                  if (retry_cnt == RW'(MAX_RETRY)) begin
                     state_nxt = FAIL;
                  end else begin
                     state_nxt = PRST;
                     retry_nxt = retry_cnt + RW'(1);
                  end
               end
            end
            QUAL: begin
               if (!lock_s) state_nxt = WAIT_LOCK;
               else if (cnt == CW'(LOCK_STABLE - 1)) state_nxt = LOCKED;
            end
            LOCKED: begin
               if (!lock_s) begin
                  state_nxt = PRST;
                  retry_nxt = '0;
               end
            end
            FAIL: begin
               state_nxt = FAIL;
            end
            default: begin
               state_nxt = PRST;
               retry_nxt = '0;
            end
         endcase
      end
   end

   // Outputs decode next-state so they move on the same edge as the state register
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         state     <= PRST;
         cnt       <= '0;
         retry_cnt <= '0;
         pll_rst   <= 1'b1;
         locked    <= 1'b0;
         sys_rst   <= 1'b1;
         fail      <= 1'b0;
      end else begin
         state     <= state_nxt;
         retry_cnt <= retry_nxt;
         if (state_nxt != state) begin
            cnt <= '0;
         end else if ((state == PRST) || (state == WAIT_LOCK) || (state == QUAL)) begin
            cnt <= cnt + CW'(1);
         end
         pll_rst <= (state_nxt == PRST) || (state_nxt == FAIL);
         locked  <= (state_nxt == LOCKED);
         sys_rst <= (state_nxt != LOCKED);
         fail    <= (state_nxt == FAIL);
      end
   end

endmodule
